// File: rtl/alu_div_pkg.sv
// Shared types and constants for the radix-2 restoring divider.
package alu_div_pkg;

   localparam int unsigned DIV_WIDTH = 32;
   localparam int unsigned DIV_LAT   = DIV_WIDTH + 1;

   typedef enum logic [1:0] {
      OP_DIV  = 2'b00,
      OP_DIVU = 2'b01,
      OP_REM  = 2'b10,
      OP_REMU = 2'b11
   } div_op_e;

   typedef enum logic [1:0] {
      S_IDLE = 2'b00,
      S_CALC = 2'b01,
      S_FIX  = 2'b10,
      S_DONE = 2'b11
   } div_state_e;

endpackage

// File: rtl/alu_div_step_unit.sv
// One combinational restoring-division step: shift in a dividend bit, trial-subtract the divisor.
module alu_div_step_unit #(
   parameter int unsigned WIDTH = 32
) (
   input  logic [WIDTH-1:0] i_rem,
   input  logic             i_bit,
   input  logic [WIDTH-1:0] i_div,
   output logic [WIDTH:0]   o_rem,
   output logic             o_qbit
);

   logic [WIDTH:0] w_shift;
   logic [WIDTH:0] w_diff;

   assign w_shift = {i_rem, i_bit};
   assign w_diff  = w_shift - {1'b0, i_div};
   assign o_qbit  = ~w_diff[WIDTH];
   assign o_rem   = o_qbit ? w_diff : w_shift;

endmodule

// File: rtl/alu_divider_32bit_unit.sv
// Multi-cycle RV32M divider (DIV/DIVU/REM/REMU): IDLE -> CALC -> FIX -> DONE.
// Define DIV_FAST_SPECIAL_EN to short-circuit divide-by-zero and signed overflow straight to DONE.
module alu_divider_32bit_unit
   import alu_div_pkg::*;
#(
   parameter int unsigned WIDTH = DIV_WIDTH
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_start,
   input  logic [1:0]       i_op,
   input  logic [WIDTH-1:0] i_a,
   input  logic [WIDTH-1:0] i_b,
   output logic             o_ready,
   output logic             o_valid,
   output logic [WIDTH-1:0] o_result
);

   localparam int unsigned     CNT_W   = $clog2(WIDTH);
   localparam logic [WIDTH-1:0] MIN_INT = {1'b1, {(WIDTH-1){1'b0}}};

   div_state_e       r_state;
   div_op_e          r_op;
   logic             r_sa, r_sb, r_bz, r_ovf;
   logic [WIDTH:0]   r_rem;
   logic [WIDTH-1:0] r_quo, r_div, r_a, r_result;
   logic [CNT_W-1:0] r_cnt;

   logic             w_signed_in, w_a_neg, w_b_neg, w_bz, w_ovf;
   logic [WIDTH-1:0] w_a_abs, w_b_abs;
   logic [WIDTH:0]   w_step_rem;
   logic             w_qbit;
   logic             w_unused_rem_msb;
   logic [WIDTH-1:0] w_q_s, w_r_s, w_q, w_r, w_fix_result;

   assign w_signed_in = ~i_op[0];
   assign w_a_neg     = w_signed_in & i_a[WIDTH-1];
   assign w_b_neg     = w_signed_in & i_b[WIDTH-1];
   assign w_a_abs     = w_a_neg ? -i_a : i_a;
   assign w_b_abs     = w_b_neg ? -i_b : i_b;
   assign w_bz        = (i_b == '0);
   assign w_ovf       = w_signed_in & (i_a == MIN_INT) & (i_b == '1);

   // The partial remainder always stays below the divisor, so its top bit never feeds the next step.
   assign w_unused_rem_msb = r_rem[WIDTH];

   alu_div_step_unit #(.WIDTH(WIDTH)) u_step (
      .i_rem  (r_rem[WIDTH-1:0]),
      .i_bit  (r_quo[WIDTH-1]),
      .i_div  (r_div),
      .o_rem  (w_step_rem),
      .o_qbit (w_qbit)
   );

   assign w_q_s = (r_sa ^ r_sb) ? -r_quo : r_quo;
   assign w_r_s = r_sa ? -r_rem[WIDTH-1:0] : r_rem[WIDTH-1:0];

   always_comb begin
      w_q = w_q_s;
      w_r = w_r_s;
      if (r_bz) begin
         w_q = '1;
         w_r = r_a;
      end else if (r_ovf) begin
         w_q = MIN_INT;
         w_r = '0;
      end
      w_fix_result = (r_op == OP_REM || r_op == OP_REMU) ? w_r : w_q;
   end

   assign o_ready  = (r_state == S_IDLE);
   assign o_valid  = (r_state == S_DONE);
   assign o_result = r_result;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state  <= S_IDLE;
         r_op     <= OP_DIV;
         r_sa     <= 1'b0;
         r_sb     <= 1'b0;
         r_bz     <= 1'b0;
         r_ovf    <= 1'b0;
         r_rem    <= '0;
         r_quo    <= '0;
         r_div    <= '0;
         r_a      <= '0;
         r_cnt    <= '0;
         r_result <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (i_start) begin
                  r_op  <= div_op_e'(i_op);
                  r_sa  <= w_a_neg;
                  r_sb  <= w_b_neg;
                  r_bz  <= w_bz;
                  r_ovf <= w_ovf;
                  r_a   <= i_a;
                  r_quo <= w_a_abs;
                  r_div <= w_b_abs;
                  r_rem <= '0;
                  r_cnt <= CNT_W'(WIDTH - 1);
`ifdef DIV_FAST_SPECIAL_EN
                  if (w_bz) begin
                     r_result <= i_op[1] ? i_a : '1;
                     r_state  <= S_DONE;
                  end else if (w_ovf) begin
                     r_result <= i_op[1] ? '0 : MIN_INT;
                     r_state  <= S_DONE;
                  end else begin
                     r_state <= S_CALC;
                  end
`else
                  r_state <= S_CALC;
`endif
               end
            end
            S_CALC: begin
               r_rem <= w_step_rem;
               r_quo <= {r_quo[WIDTH-2:0], w_qbit};
               if (r_cnt == '0) begin
                  r_state <= S_FIX;
               end else begin
                  r_cnt <= r_cnt - 1'b1;
               end
            end
            S_FIX: begin
               r_result <= w_fix_result;
               r_state  <= S_DONE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_divider_32bit_unit.sv
// Self-checking bench for alu_divider_32bit_unit: directed vectors, random ops vs. an arithmetic model, abort/ignore sequences.
module tb_alu_divider_32bit_unit;
   import alu_div_pkg::*;

   logic        clk = 1'b0;
   logic        i_rst, i_start;
   logic [1:0]  i_op;
   logic [31:0] i_a, i_b;
   logic        o_ready, o_valid;
   logic [31:0] o_result;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;

   alu_divider_32bit_unit #(.WIDTH(32)) dut (
      .i_clk    (clk),
      .i_rst    (i_rst),
      .i_start  (i_start),
      .i_op     (i_op),
      .i_a      (i_a),
      .i_b      (i_b),
      .o_ready  (o_ready),
      .o_valid  (o_valid),
      .o_result (o_result)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [1:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] exp;
   } vec_t;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
      logic [31:0] q, r;
      if (b == 32'd0) begin
         q = 32'hFFFF_FFFF;
         r = a;
      end else if (op[0] == 1'b0) begin
         if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            q = 32'h8000_0000;
            r = 32'd0;
         end else begin
            q = $signed(a) / $signed(b);
            r = $signed(a) % $signed(b);
         end
      end else begin
         q = a / b;
         r = a % b;
      end
      return op[1] ? r : q;
   endfunction

   function automatic int exp_lat(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
`ifdef DIV_FAST_SPECIAL_EN
      if (b == 32'd0 || (op[0] == 1'b0 && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)) return 0;
`endif
      return DIV_LAT;
   endfunction

   // Issues one op from IDLE, returns result, latency (edges after accept) and accept cycle.
   task automatic do_op(input string name, input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] res, output int lat, output int acc_cyc);
      int ready_bad;
      ready_bad = 0;
      res = 32'hDEAD_BEEF;
      lat = -1;
      @(negedge clk);
      i_start = 1'b1; i_op = op; i_a = a; i_b = b;
      @(posedge clk);
      acc_cyc = cyc;
      #1;
      i_start = 1'b0;
      i_a = $urandom; i_b = $urandom; i_op = 2'($urandom);
      if (o_valid) begin
         lat = 0;
         res = o_result;
      end
      for (int n = 1; n <= 60 && lat < 0; n++) begin
         @(posedge clk); #1;
         if (o_valid) begin
            lat = n;
            res = o_result;
         end else if (o_ready) begin
            ready_bad++;
         end
      end
      if (lat < 0) begin
         n_checks++; n_fail++;
         $display("FAIL %s timeout: no o_valid within 60 cycles", name);
      end else begin
         check({name, " result"}, res, model(op, a, b));
         check({name, " latency"}, 32'(lat), 32'(exp_lat(op, a, b)));
         check({name, " ready_low_while_busy"}, 32'(ready_bad), 32'd0);
         @(posedge clk); #1;
         check({name, " valid_pulse_width"}, {31'd0, o_valid}, 32'd0);
         check({name, " ready_after_done"}, {31'd0, o_ready}, 32'd1);
         check({name, " result_held"}, o_result, res);
      end
   endtask

   vec_t        vecs[$];
   logic [31:0] res, res2;
   int          lat, lat2, acc, acc2, pulses;
   logic [1:0]  rop;
   logic [31:0] ra, rb;

   initial begin
      vecs.push_back('{2'b01, 32'd100,        32'd7,          32'd14});
      vecs.push_back('{2'b10, 32'hFFFF_FF9C,  32'd7,          32'hFFFF_FFFE});
      vecs.push_back('{2'b00, 32'hFFFF_FF9C,  32'd7,          32'hFFFF_FFF2});
      vecs.push_back('{2'b00, 32'h1234_5678,  32'd0,          32'hFFFF_FFFF});
      vecs.push_back('{2'b10, 32'h1234_5678,  32'd0,          32'h1234_5678});
      vecs.push_back('{2'b01, 32'h1234_5678,  32'd0,          32'hFFFF_FFFF});
      vecs.push_back('{2'b11, 32'hFFFF_FF9C,  32'd0,          32'hFFFF_FF9C});
      vecs.push_back('{2'b00, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000});
      vecs.push_back('{2'b10, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0});
      vecs.push_back('{2'b01, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0});
      vecs.push_back('{2'b11, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000});
      vecs.push_back('{2'b00, 32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD});
      vecs.push_back('{2'b10, 32'd7,          32'hFFFF_FFFE,  32'd1});
      vecs.push_back('{2'b11, 32'd5,          32'd10,         32'd5});
      vecs.push_back('{2'b01, 32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF});

      i_rst = 1'b1; i_start = 1'b0; i_op = 2'b00; i_a = '0; i_b = '0;
      repeat (3) @(posedge clk);
      #1;
      check("reset o_ready", {31'd0, o_ready}, 32'd1);
      check("reset o_valid", {31'd0, o_valid}, 32'd0);
      check("reset o_result", o_result, 32'd0);
      @(negedge clk);
      i_rst = 1'b0;

      foreach (vecs[i]) begin
         do_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, res, lat, acc);
         check($sformatf("vec%0d table_expect", i), res, vecs[i].exp);
      end

      // Back-to-back DIVU pair: valid edges at 33 and 68 relative to the first accept.
      do_op("b2b first", 2'b01, 32'hFFFF_FFFF, 32'd1, res, lat, acc);
      do_op("b2b second", 2'b01, 32'd5, 32'd10, res2, lat2, acc2);
      check("b2b second accept edge", 32'(acc2 - acc), 32'd35);
      check("b2b second valid edge", 32'(acc2 + lat2 - acc), 32'd68);

      // Start while busy is ignored and not queued.
      @(negedge clk);
      i_start = 1'b1; i_op = 2'b01; i_a = 32'd1000; i_b = 32'd3;
      @(posedge clk); #1;
      i_start = 1'b0;
      lat = -1; pulses = 0;
      for (int k = 1; k <= 80; k++) begin
         if (k == 9) begin i_start = 1'b1; i_a = 32'd9; i_b = 32'd3; end
         if (k == 10) i_start = 1'b0;
         @(posedge clk); #1;
         if (o_valid) begin
            pulses++;
            if (lat < 0) begin lat = k; res = o_result; end
         end
      end
      check("ignored start result", res, 32'd333);
      check("ignored start latency", 32'(lat), 32'd33);
      check("ignored start single pulse", 32'(pulses), 32'd1);

      // Reset mid-operation aborts without a valid pulse.
      @(negedge clk);
      i_start = 1'b1; i_op = 2'b00; i_a = 32'hFFFF_F000; i_b = 32'd5;
      @(posedge clk); #1;
      i_start = 1'b0;
      pulses = 0;
      for (int k = 1; k <= 20; k++) begin
         if (k == 19) i_rst = 1'b1;
         @(posedge clk); #1;
         if (o_valid) pulses++;
      end
      i_rst = 1'b0;
      check("abort o_ready", {31'd0, o_ready}, 32'd1);
      check("abort o_valid", {31'd0, o_valid}, 32'd0);
      check("abort o_result", o_result, 32'd0);
      for (int k = 0; k < 40; k++) begin
         @(posedge clk); #1;
         if (o_valid) pulses++;
      end
      check("abort no valid pulse", 32'(pulses), 32'd0);

      // Reset and start together: reset wins.
      @(negedge clk);
      i_rst = 1'b1; i_start = 1'b1; i_op = 2'b01; i_a = 32'd50; i_b = 32'd5;
      @(posedge clk); #1;
      i_rst = 1'b0; i_start = 1'b0;
      check("rst+start stays idle", {31'd0, o_ready}, 32'd1);

      for (int i = 0; i < 40; i++) begin
         rop = 2'($urandom);
         ra  = $urandom;
         case ($urandom_range(0, 3))
            0: rb = 32'($urandom_range(1, 20));
            1: rb = (ra[0]) ? 32'd0 : 32'hFFFF_FFFF;
            default: rb = $urandom;
         endcase
         if (i % 10 == 3) ra = 32'h8000_0000;
         do_op($sformatf("rnd%0d op%0d a=%08h b=%08h", i, rop, ra, rb), rop, ra, rb, res, lat, acc);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
